// File: rtl/pll_reconfig_seq_pkg.sv
// Shared constants, state encoding and request validation for the video PLL
// reconfiguration sequencer.
package pll_reconfig_pkg;

    // Reconfig-controller register addresses
    localparam logic [5:0] PLL_A_MODE  = 6'd0;
    localparam logic [5:0] PLL_A_START = 6'd2;
    localparam logic [5:0] PLL_A_N     = 6'd3;
    localparam logic [5:0] PLL_A_M     = 6'd4;
    localparam logic [5:0] PLL_A_C     = 6'd5;
    localparam logic [5:0] PLL_A_K     = 6'd7;
    localparam logic [5:0] PLL_A_BW    = 6'd8;
    localparam logic [5:0] PLL_A_CP    = 6'd9;

    // Number of register writes in one reconfiguration sequence
    localparam int         STEP_COUNT  = 8;
    localparam logic [2:0] LAST_STEP   = 3'(STEP_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // 0 and 511 cannot be expressed in the controller's counter format
    function automatic logic div_valid(input logic [8:0] d);
        return (d != 9'd0) && (d != 9'd511);
    endfunction

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Write port towards the clock-crossing PLL FIFO.
interface pll_reconfig_seq_if;
    logic [5:0]  pll_addr;
    logic [31:0] pll_value;
    logic        pll_write;
    logic        pll_busy;

    modport master (output pll_addr, output pll_value, output pll_write, input pll_busy);
    modport slave  (input pll_addr, input pll_value, input pll_write, output pll_busy);
endinterface

// File: rtl/pll_reconfig_seq_counter_enc.sv
// Integer divider to reconfig-controller counter word (bypass / odd / high / low).
module pll_counter_enc (
    input  logic [8:0]  div_i,
    output logic [31:0] enc_o
);

    // Divider 1 uses bypass; otherwise split into high/low counts with odd flag
    always_comb begin
        enc_o = 32'd0;
        if (div_i == 9'd1) begin
            enc_o[16] = 1'b1;
        end else begin
            enc_o[17]   = div_i[0];
            enc_o[15:8] = div_i[8:1] + {7'd0, div_i[0]};
            enc_o[7:0]  = div_i[8:1];
        end
    end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Turns one PLL request into the ordered 8-write stream for the reconfig
// controller, honouring FIFO back-pressure.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int BW_VALUE = 6,
    parameter int CP_VALUE = 2,
    parameter int C_INDEX  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req,
    input  logic [8:0]                n_div,
    input  logic [8:0]                m_div,
    input  logic [8:0]                c_div,
    input  logic [31:0]               k_frac,
    pll_reconfig_seq_if.master        fifo,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam logic [31:0] BW_WORD = 32'(BW_VALUE);
    localparam logic [31:0] CP_WORD = 32'(CP_VALUE);
    localparam logic [4:0]  C_IDX   = 5'(C_INDEX);

    state_e      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [8:0]  n_q, m_q, c_q;
    logic [31:0] k_q;
    logic [31:0] enc_n_s, enc_m_s, enc_c_s;
    logic [31:0] enc_n_q, enc_m_q, c_word_q;
    logic [5:0]  addr_q, word_addr_s;
    logic [31:0] value_q, word_value_s;
    logic        busy_q, done_q, err_q, err_d;
    logic [2:0]  sel_step_s;
    logic        load_word_s, latch_req_s, load_enc_s;
    logic        req_valid_s, write_s;

    assign req_valid_s = div_valid(n_div) & div_valid(m_div) & div_valid(c_div);
    assign write_s     = (state_q == ST_EMIT) & ~fifo.pll_busy;

    assign fifo.pll_write = write_s;
    assign fifo.pll_addr  = addr_q;
    assign fifo.pll_value = value_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

    pll_counter_enc u_enc_n (.div_i(n_q), .enc_o(enc_n_s));
    pll_counter_enc u_enc_m (.div_i(m_q), .enc_o(enc_m_s));
    pll_counter_enc u_enc_c (.div_i(c_q), .enc_o(enc_c_s));

    // Address/value presented at each sequence step
    always_comb begin
        word_addr_s  = PLL_A_MODE;
        word_value_s = 32'd0;
        case (sel_step_s)
            3'd0:    begin word_addr_s = PLL_A_MODE;  word_value_s = 32'd0;    end
            3'd1:    begin word_addr_s = PLL_A_N;     word_value_s = enc_n_q;  end
            3'd2:    begin word_addr_s = PLL_A_M;     word_value_s = enc_m_q;  end
            3'd3:    begin word_addr_s = PLL_A_K;     word_value_s = k_q;      end
            3'd4:    begin word_addr_s = PLL_A_BW;    word_value_s = BW_WORD;  end
            3'd5:    begin word_addr_s = PLL_A_CP;    word_value_s = CP_WORD;  end
            3'd6:    begin word_addr_s = PLL_A_C;     word_value_s = c_word_q; end
            3'd7:    begin word_addr_s = PLL_A_START; word_value_s = 32'd1;    end
            default: begin word_addr_s = PLL_A_MODE;  word_value_s = 32'd0;    end
        endcase
    end

    // Next-state, step advance and output-word load decisions
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        sel_step_s  = step_q;
        load_word_s = 1'b0;
        latch_req_s = 1'b0;
        load_enc_s  = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_valid_s) begin
                        state_d     = ST_ENC;
                        latch_req_s = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENC: begin
                // Step 0 is constant, so it can be loaded before the encodings land
                state_d     = ST_EMIT;
                step_d      = 3'd0;
                sel_step_s  = 3'd0;
                load_word_s = 1'b1;
                load_enc_s  = 1'b1;
            end
            ST_EMIT: begin
                if (write_s) begin
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                        step_d  = 3'd0;
                    end else begin
                        step_d      = step_q + 3'd1;
                        sel_step_s  = step_q + 3'd1;
                        load_word_s = 1'b1;
                    end
                end else begin
                    step_d = step_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, step, latched request, encoded counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            step_q   <= 3'd0;
            n_q      <= 9'd0;
            m_q      <= 9'd0;
            c_q      <= 9'd0;
            k_q      <= 32'd0;
            enc_n_q  <= 32'd0;
            enc_m_q  <= 32'd0;
            c_word_q <= 32'd0;
            addr_q   <= 6'd0;
            value_q  <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (latch_req_s) begin
                n_q <= n_div;
                m_q <= m_div;
                c_q <= c_div;
                k_q <= k_frac;
            end
            if (load_enc_s) begin
                enc_n_q  <= enc_n_s;
                enc_m_q  <= enc_m_s;
                c_word_q <= enc_c_s | {9'd0, C_IDX, 18'd0};
            end
            if (load_word_s) begin
                addr_q  <= word_addr_s;
                value_q <= word_value_s;
            end
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_d == ST_DONE);
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Randomized self-checking bench for pll_reconfig_seq against a write-list model.
module tb_pll_reconfig_seq;

    localparam int TB_BW = 6;
    localparam int TB_CP = 2;
    localparam int TB_CI = 0;

    logic        clk;
    logic        reset;
    logic        req;
    logic [8:0]  n_div, m_div, c_div;
    logic [31:0] k_frac;
    logic        busy, done, err;
    int          n_tests = 0;
    int          n_fail  = 0;

    pll_reconfig_seq_if fifo_if ();

    pll_reconfig_seq #(.BW_VALUE(TB_BW), .CP_VALUE(TB_CP), .C_INDEX(TB_CI)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .n_div  (n_div),
        .m_div  (m_div),
        .c_div  (c_div),
        .k_frac (k_frac),
        .fifo   (fifo_if),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counter word from the arithmetic definition
    function automatic logic [31:0] ref_enc(input int d);
        if (d == 1) return 32'h0001_0000;
        return 32'((d % 2) * 131072 + ((d + 1) / 2) * 256 + (d / 2));
    endfunction

    // One request: stall burst of stall_len cycles when stall_step is next to be written
    task automatic run_req(input logic [8:0] n, input logic [8:0] m, input logic [8:0] c,
                           input logic [31:0] k, input int stall_step, input int stall_len,
                           input bit mid_req);
        logic [5:0]  ea[$];
        logic [31:0] ev[$];
        int  idx = 0;
        int  stalls = 0;
        int  done_at;
        int  n_done = 0;
        bit  mid_sent = 1'b0;
        bit  bad;
        bad = (n == 9'd0) || (n == 9'd511) || (m == 9'd0) || (m == 9'd511) ||
              (c == 9'd0) || (c == 9'd511);
        done_at = 10 + stall_len;
        ea = '{6'd0, 6'd3, 6'd4, 6'd7, 6'd8, 6'd9, 6'd5, 6'd2};
        ev = '{32'd0, ref_enc(int'(n)), ref_enc(int'(m)), k, 32'(TB_BW), 32'(TB_CP),
               ref_enc(int'(c)) | (32'(TB_CI) << 18), 32'd1};
        @(posedge clk); #1;
        req = 1'b1; n_div = n; m_div = m; c_div = c; k_frac = k;
        fifo_if.pll_busy = 1'b0;
        for (int cyc = 1; cyc <= done_at + 3; cyc++) begin
            @(posedge clk); #1;
            req = 1'b0;
            n_div = 9'($urandom); m_div = 9'($urandom); c_div = 9'($urandom); k_frac = $urandom;
            if (mid_req && !mid_sent && idx == 4) begin
                req = 1'b1;
                mid_sent = 1'b1;
            end
            fifo_if.pll_busy = !bad && cyc >= 2 && idx == stall_step && stalls < stall_len;
            if (fifo_if.pll_busy) stalls++;
            @(negedge clk);
            check_val("busy", 32'(busy), 32'(!bad && cyc <= done_at));
            check_val("err", 32'(err), 32'(bad && cyc == 1));
            check_val("done", 32'(done), 32'(!bad && cyc == done_at));
            if (done) n_done++;
            if (fifo_if.pll_write) begin
                if (idx < 8) begin
                    check_val("wr_addr", 32'(fifo_if.pll_addr), 32'(ea[idx]));
                    check_val("wr_value", fifo_if.pll_value, ev[idx]);
                end else begin
                    check_val("extra_write", 32'(idx + 1), 32'd8);
                end
                idx++;
            end else if (fifo_if.pll_busy && idx < 8) begin
                check_val("stall_addr", 32'(fifo_if.pll_addr), 32'(ea[idx]));
                check_val("stall_value", fifo_if.pll_value, ev[idx]);
            end
        end
        fifo_if.pll_busy = 1'b0;
        check_val("n_writes", 32'(idx), bad ? 32'd0 : 32'd8);
        check_val("n_done", 32'(n_done), bad ? 32'd0 : 32'd1);
    endtask

    // Reset after the third write, with a request colliding with reset
    task automatic reset_mid();
        int writes = 0;
        @(posedge clk); #1;
        req = 1'b1; n_div = 9'd7; m_div = 9'd9; c_div = 9'd3; k_frac = $urandom;
        fifo_if.pll_busy = 1'b0;
        for (int cyc = 1; cyc <= 12 && writes < 3; cyc++) begin
            @(posedge clk); #1;
            req = 1'b0;
            @(negedge clk);
            if (fifo_if.pll_write) writes++;
        end
        check_val("rst_pre_writes", 32'(writes), 32'd3);
        @(posedge clk); #1;
        reset = 1'b1;
        req   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        check_val("rst_write", 32'(fifo_if.pll_write), 32'd0);
        check_val("rst_addr", 32'(fifo_if.pll_addr), 32'd0);
        check_val("rst_value", fifo_if.pll_value, 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("rst_quiet_write", 32'(fifo_if.pll_write), 32'd0);
            check_val("rst_quiet_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0;
        n_div = 9'd0; m_div = 9'd0; c_div = 9'd0; k_frac = 32'd0;
        fifo_if.pll_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_write", 32'(fifo_if.pll_write), 32'd0);
        check_val("reset_addr", 32'(fifo_if.pll_addr), 32'd0);
        check_val("reset_value", fifo_if.pll_value, 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_done", 32'(done), 32'd0);
        check_val("reset_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_req(9'd1, 9'd5, 9'd4, 32'h8000_0000, 0, 0, 1'b0);
        run_req(9'd1, 9'd5, 9'd4, 32'h8000_0000, 3, 4, 1'b0);
        run_req(9'd3, 9'd0, 9'd4, 32'h1234_5678, 0, 0, 1'b0);
        run_req(9'd3, 9'd6, 9'd511, 32'h1234_5678, 0, 0, 1'b0);
        run_req(9'd12, 9'd40, 9'd7, 32'hDEAD_BEEF, 0, 0, 1'b1);
        reset_mid();
        run_req(9'd2, 9'd3, 9'd510, 32'h0000_0001, 0, 0, 1'b0);
        run_req(9'd510, 9'd2, 9'd3, 32'hFFFF_FFFF, 7, 2, 1'b0);

        for (int t = 0; t < 12; t++) begin
            logic [8:0] rn, rm, rc;
            rn = 9'($urandom_range(1, 510));
            rm = 9'($urandom_range(1, 510));
            rc = 9'($urandom_range(1, 510));
            if ($urandom_range(0, 7) == 0) rm = ($urandom_range(0, 1) == 0) ? 9'd0 : 9'd511;
            run_req(rn, rm, rc, $urandom, int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
